// File: rtl/cmp_search_fsm.sv
// cmp_search_fsm: binary-search initiator for a magnitude comparator.
//
// The block owns the comparator's B operand (outGuess) and reads back the
// one-hot result {inGT, inEQ, inLT} of comparing a hidden A against it. Each
// PROBE cycle narrows the window [lo, hi] until the comparator reports
// equality (DONE) or the responses become impossible or malformed (ERR).
//
// Ports:
//   clk       system clock, rising edge active
//   reset     asynchronous, active-high reset
//   inStart   one-cycle search request, honoured only in IDLE, DONE or ERR
//   outGuess  registered probe value, wired to the comparator B operand
//   inGT      comparator result A >  outGuess
//   inEQ      comparator result A == outGuess
//   inLT      comparator result A <  outGuess
//   outBusy   high while probing
//   outDone   high while a found value is presented
//   outError  high after a malformed or contradictory comparator response
//   outValue  found value, valid while outDone is high
//   outCount  number of probes issued in the current or last search
module cmp_search_fsm #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inStart,
  output logic [WIDTH-1:0] outGuess,
  input  logic             inGT,
  input  logic             inEQ,
  input  logic             inLT,
  output logic             outBusy,
  output logic             outDone,
  output logic             outError,
  output logic [WIDTH-1:0] outValue,
  output logic [WIDTH-1:0] outCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  // The first probe is the midpoint of the full range.
  localparam logic [WIDTH-1:0] MID_V  = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] guess_r, guess_s;
  logic [WIDTH-1:0] value_r, value_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             error_r, error_s;
  logic [2:0]       cmp_s;

  assign cmp_s = {inGT, inEQ, inLT};

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      lo_r    <= ZERO_V;
      hi_r    <= ZERO_V;
      guess_r <= ZERO_V;
      value_r <= ZERO_V;
      count_r <= ZERO_V;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      guess_r <= guess_s;
      value_r <= value_s;
      count_r <= count_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_s = state_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    guess_s = guess_r;
    value_s = value_r;
    count_s = count_r;
    busy_s  = busy_r;
    done_s  = done_r;
    error_s = error_r;

    case (state_r)
      IDLE, DONE, ERR: begin
        if (inStart) begin
          state_s = PROBE;
          lo_s    = ZERO_V;
          hi_s    = MAX_V;
          guess_s = MID_V;
          count_s = ONE_V;
          value_s = ZERO_V;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          error_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      PROBE: begin
        case (cmp_s)
          3'b010: begin
            value_s = guess_r;
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end
          3'b100: begin
            // A above the current upper bound cannot exist.
            if (guess_r == hi_r) begin
              state_s = ERR;
              busy_s  = 1'b0;
              error_s = 1'b1;
            end else begin
              lo_s    = guess_r + ONE_V;
              guess_s = lo_s + ((hi_r - lo_s) >> 1);
              count_s = count_r + ONE_V;
            end
          end
          3'b001: begin
            // A below the current lower bound cannot exist.
            if (guess_r == lo_r) begin
              state_s = ERR;
              busy_s  = 1'b0;
              error_s = 1'b1;
            end else begin
              hi_s    = guess_r - ONE_V;
              guess_s = lo_r + ((hi_s - lo_r) >> 1);
              count_s = count_r + ONE_V;
            end
          end
          default: begin
            // No bit or several bits set: the comparator is not trustworthy.
            state_s = ERR;
            busy_s  = 1'b0;
            error_s = 1'b1;
          end
        endcase
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        error_s = 1'b0;
      end
    endcase
  end

  assign outGuess = guess_r;
  assign outValue = value_r;
  assign outCount = count_r;
  assign outBusy  = busy_r;
  assign outDone  = done_r;
  assign outError = error_r;

endmodule

// File: tb/tb_cmp_search_fsm.sv
// Directed bench for cmp_search_fsm: a WIDTH=4 instance driven by a
// configurable comparator responder and a WIDTH=2 instance wired to an
// ideal 2-bit comparator.
module tb_cmp_search_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance and its responder
  logic       start4 = 1'b0;
  logic [3:0] guess4, value4, count4;
  logic       busy4, done4, err4;
  logic       gt4, eq4, lt4;
  logic [3:0] a4 = 4'd0;
  int         mode = 0; // 0 ideal, 1 none set, 2 GT+LT, 3 always GT, 4 always LT

  // Responder: ideal comparator or one of the faulty behaviours.
  always_comb begin
    case (mode)
      0:       {gt4, eq4, lt4} = {a4 > guess4, a4 == guess4, a4 < guess4};
      1:       {gt4, eq4, lt4} = 3'b000;
      2:       {gt4, eq4, lt4} = 3'b101;
      3:       {gt4, eq4, lt4} = 3'b100;
      4:       {gt4, eq4, lt4} = 3'b001;
      default: {gt4, eq4, lt4} = 3'b000;
    endcase
  end

  cmp_search_fsm #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .inStart(start4), .outGuess(guess4),
    .inGT(gt4), .inEQ(eq4), .inLT(lt4), .outBusy(busy4), .outDone(done4),
    .outError(err4), .outValue(value4), .outCount(count4)
  );

  // WIDTH=2 instance wired to an ideal 2-bit comparator
  logic       start2 = 1'b0;
  logic [1:0] guess2, value2, count2;
  logic       busy2, done2, err2;
  logic [1:0] a2 = 2'd0;
  wire        gt2 = a2 > guess2;
  wire        eq2 = a2 == guess2;
  wire        lt2 = a2 < guess2;

  cmp_search_fsm #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .inStart(start2), .outGuess(guess2),
    .inGT(gt2), .inEQ(eq2), .inLT(lt2), .outBusy(busy2), .outDone(done2),
    .outError(err2), .outValue(value2), .outCount(count2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected guess sequence for run4 when check_g is set.
  logic [3:0] gseq [8];
  int         glen = 0;
  int         last_cycles = 0;

  // Pulse start on dut4, then step until a result state or the cycle bound.
  task automatic run4(input int check_g);
    int n;
    n = 0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    if (check_g != 0) begin
      chk("start_clears_value", int'(value4), 0);
      chk("start_clears_done", int'(done4), 0);
      chk("busy_in_probe", int'(busy4), 1);
    end
    while (!(done4 || err4) && n < 20) begin
      if (check_g != 0 && n < glen) chk($sformatf("guess[%0d]", n), int'(guess4), int'(gseq[n]));
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("run4_timeout", n, 0);
    last_cycles = n;
  endtask

  typedef struct {
    logic [3:0] a;
    int         mode;
    logic       done;
    logic       err;
    logic [3:0] value;
    logic [3:0] count;
    logic [3:0] guess;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{4'd7,  0, 1'b1, 1'b0, 4'd7,  4'd1, 4'd7};
    vt[1] = '{4'd15, 0, 1'b1, 1'b0, 4'd15, 4'd5, 4'd15};
    vt[2] = '{4'd0,  0, 1'b1, 1'b0, 4'd0,  4'd4, 4'd0};
    vt[3] = '{4'd0,  1, 1'b0, 1'b1, 4'd0,  4'd1, 4'd7};
    vt[4] = '{4'd9,  0, 1'b1, 1'b0, 4'd9,  4'd3, 4'd9};
    vt[5] = '{4'd0,  2, 1'b0, 1'b1, 4'd0,  4'd1, 4'd7};
    vt[6] = '{4'd3,  0, 1'b1, 1'b0, 4'd3,  4'd2, 4'd3};
    vt[7] = '{4'd0,  3, 1'b0, 1'b1, 4'd0,  4'd5, 4'd15};
    vt[8] = '{4'd8,  0, 1'b1, 1'b0, 4'd8,  4'd4, 4'd8};
    vt[9] = '{4'd0,  4, 1'b0, 1'b1, 4'd0,  4'd4, 4'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_guess", int'(guess4), 0);
    chk("rst_count", int'(count4), 0);
    chk("rst_flags", int'({busy4, done4, err4}), 0);
    chk("rst_value", int'(value4), 0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven searches
    for (int i = 0; i < 10; i++) begin
      a4 = vt[i].a;
      mode = vt[i].mode;
      run4(0);
      chk($sformatf("v%0d_done", i), int'(done4), int'(vt[i].done));
      chk($sformatf("v%0d_err", i), int'(err4), int'(vt[i].err));
      chk($sformatf("v%0d_busy", i), int'(busy4), 0);
      chk($sformatf("v%0d_count", i), int'(count4), int'(vt[i].count));
      chk($sformatf("v%0d_latency", i), last_cycles, int'(vt[i].count));
      chk($sformatf("v%0d_guess", i), int'(guess4), int'(vt[i].guess));
      if (vt[i].done) chk($sformatf("v%0d_value", i), int'(value4), int'(vt[i].value));
      else chk($sformatf("v%0d_value", i), int'(value4), 0);
    end

    // Result state holds through idle cycles (last vector left ERR)
    repeat (3) @(posedge clk);
    #1;
    chk("hold_err", int'(err4), 1);
    chk("hold_count", int'(count4), 4);
    chk("hold_guess", int'(guess4), 0);

    // A=15 with explicit guess sequence, then A=0
    mode = 0;
    a4 = 4'd15;
    gseq[0] = 4'd7; gseq[1] = 4'd11; gseq[2] = 4'd13; gseq[3] = 4'd14; gseq[4] = 4'd15;
    glen = 5;
    run4(1);
    chk("seq15_value", int'(value4), 15);
    chk("seq15_count", int'(count4), 5);
    a4 = 4'd0;
    gseq[0] = 4'd7; gseq[1] = 4'd3; gseq[2] = 4'd1; gseq[3] = 4'd0;
    glen = 4;
    run4(1);
    chk("seq0_done", int'(done4), 1);
    chk("seq0_value", int'(value4), 0);
    chk("seq0_count", int'(count4), 4);

    // Always-GT responder: guesses run up to 15, then ERR
    mode = 3;
    gseq[0] = 4'd7; gseq[1] = 4'd11; gseq[2] = 4'd13; gseq[3] = 4'd14; gseq[4] = 4'd15;
    glen = 5;
    run4(1);
    chk("gt_err", int'(err4), 1);
    chk("gt_count", int'(count4), 5);

    // Reset during the third probe of an A=12 search
    mode = 0;
    a4 = 4'd12;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("a12_third_guess", int'(guess4), 13);
    chk("a12_third_count", int'(count4), 3);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_guess", int'(guess4), 0);
    chk("midrst_count", int'(count4), 0);
    chk("midrst_flags", int'({busy4, done4, err4}), 0);
    chk("midrst_value", int'(value4), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_stays_idle", int'({busy4, done4, err4}), 0);

    // inStart during PROBE of an A=5 search is ignored
    a4 = 4'd5;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    chk("a5_g0", int'(guess4), 7);
    @(posedge clk);
    #1;
    chk("a5_g1", int'(guess4), 3);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    chk("a5_g2_no_restart", int'(guess4), 5);
    chk("a5_count2", int'(count4), 3);
    @(posedge clk);
    #1;
    chk("a5_done", int'(done4), 1);
    chk("a5_value", int'(value4), 5);
    chk("a5_count", int'(count4), 3);

    // WIDTH=2 sweep against the 2-bit comparator
    for (int a = 0; a < 4; a++) begin
      int n;
      int exp_cnt;
      exp_cnt = (a == 1) ? 1 : (a == 3) ? 3 : 2;
      a2 = a[1:0];
      n = 0;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      while (!(done2 || err2) && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("w2_a%0d_done", a), int'(done2), 1);
      chk($sformatf("w2_a%0d_value", a), int'(value2), a);
      chk($sformatf("w2_a%0d_count", a), int'(count2), exp_cnt);
      chk($sformatf("w2_a%0d_latency", a), n, exp_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
